perf_monitor: RTL and testbench
===============================

Name: perf_monitor

Overview:
Synthesizable, parametrised performance monitor that sits beside the pipeline core. It observes the debug PC, the instruction-valid strobe and N_CH watched IO output channels. It counts cycles, retired instructions and bubble cycles, and time-stamps the first change on each channel. At the end of a run it computes IPC in Q8.8 with an iterative divider, giving in hardware the same figures the cycle-counting benches compute.

Parameters:
CNT_W, 32, width of all cycle/instruction/bubble/timestamp counters
PC_W, 32, width of the observed debug PC
DATA_W, 32, width of each watched channel
N_CH, 2, number of watched channels (1..8)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_clr  in  1  synchronous clear; returns the block to IDLE
i_stop  in  1  manual stop request; used in RUN
i_stop_mask  in  N_CH  channels whose first change ends the run; held static during RUN
i_pc_debug  in  PC_W  core debug PC; value 0 = bubble/flush slot
i_insn_vld  in  1  instruction retired this cycle
i_ch_data  in  N_CH*DATA_W  watched channels; channel k = bits [k*DATA_W +: DATA_W]
o_state  out  2  0 IDLE, 1 RUN, 2 CALC, 3 DONE
o_cycle_cnt  out  CNT_W  RUN cycles
o_insn_cnt  out  CNT_W  retired instructions in RUN
o_bubble_cnt  out  CNT_W  RUN cycles with i_pc_debug == 0
o_ch_changed  out  N_CH  first change seen, per channel
o_ch_time  out  N_CH*CNT_W  o_cycle_cnt value in the cycle channel k first changed
o_ch_value  out  N_CH*DATA_W  channel value captured at first change
o_ovf  out  1  sticky; a counter saturated
o_ipc_q88  out  16  IPC = insn*256/cycle, Q8.8, valid when o_done
o_done  out  1  high in DONE

Behaviour:
- Reset and i_clr clear everything to 0:
  - all outputs, including o_state = IDLE;
  - channel shadow registers.
- i_clr has top priority in every state, including over i_stop and the stop condition.
- Shadow registers sample i_ch_data every cycle in all states. A channel "changes" when i_ch_data[k] != shadow[k].
- IDLE:
  - All counters hold at 0.
  - On the first edge where i_pc_debug != 0, go to RUN. That edge counts as RUN cycle 1, and its insn/bubble/channel events are counted.
- RUN, every edge:
  - cycle_cnt += 1.
  - insn_cnt += i_insn_vld.
  - bubble_cnt += (i_pc_debug == 0).
  - For each k with a change and !changed[k]: set changed[k], ch_time[k] = the updated cycle_cnt (1-based), ch_value[k] = i_ch_data[k].
  - Later changes on an already-captured channel are ignored.
- Counters saturate at 2^CNT_W-1 and set o_ovf. They never wrap. ch_time captures the saturated value.
- Stop condition: (i_stop_mask != 0 and every masked channel has changed, counting captures made this edge) or i_stop.
  - The stopping edge's counts are included. The next state is CALC.
  - If i_stop_mask == 0, only i_stop ends the run.
- CALC: restoring division of {insn_cnt, 8'b0} by cycle_cnt.
  - Exactly CNT_W+8 cycles, one quotient bit per cycle.
  - Result is truncated. A quotient > 16'hFFFF saturates to 16'hFFFF.
  - cycle_cnt == 0 gives a result of 0.
  - Counters are frozen. i_stop is ignored.
- DONE:
  - o_ipc_q88 is loaded on the CALC→DONE edge. o_done = 1.
  - All results hold until i_clr or reset.
- Reset asserted mid-RUN or mid-CALC: immediate clear. No partial result is visible.
- i_insn_vld while i_pc_debug == 0 is counted both as an instruction and as a bubble.

Test Plan:
1. CNT_W=16, N_CH=2, mask=01: PC=0 for 3 cycles, then nonzero with insn_vld=1 for 10 cycles; ch0 changes 0→120 on the 10th RUN cycle.
   -> cycle=10, insn=10, bubble=0, ch_time0=10, ch_value0=120, changed=01.
   -> DONE exactly 24 cycles after the stop edge; ipc=0x0100.
2. Same setup, 20 RUN cycles; PC=0 with insn_vld=0 on 5 of them; i_stop on the 20th.
   -> cycle=20, insn=15, bubble=5, ipc=0x00C0.
3. mask=11: ch1 changes at RUN cycle 4 and again at cycle 6; ch0 changes at cycle 12.
   -> stop at 12; ch_time1=4 (second change ignored); ch_time0=12; cycle=12.
4. mask=00: channel changes alone do not stop the run; i_stop at RUN cycle 7 -> cycle=7.
   -> Repeat with i_clr and i_stop on the same edge -> state=IDLE, all counters 0.
5. CNT_W=8: RUN 300 cycles with insn_vld=1, then i_stop.
   -> cycle=255, insn=255, o_ovf=1, ipc=0x0100.
6. Reset deasserted-asserted mid-CALC -> all outputs 0 asynchronously. After release, PC nonzero re-arms RUN from cycle 1.

Source files
------------

// File: rtl/perf_monitor.sv
// perf_monitor - run-time cycle/instruction/bubble counters, per-channel first-change
// timestamps and a serial Q8.8 IPC divider. CNT_W must be at least 8.
module perf_monitor #(
  parameter int CNT_W  = 32,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int N_CH   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_stop,
  input  logic [N_CH-1:0]          i_stop_mask,
  input  logic [PC_W-1:0]          i_pc_debug,
  input  logic                     i_insn_vld,
  input  logic [N_CH*DATA_W-1:0]   i_ch_data,
  output logic [1:0]               o_state,
  output logic [CNT_W-1:0]         o_cycle_cnt,
  output logic [CNT_W-1:0]         o_insn_cnt,
  output logic [CNT_W-1:0]         o_bubble_cnt,
  output logic [N_CH-1:0]          o_ch_changed,
  output logic [N_CH*CNT_W-1:0]    o_ch_time,
  output logic [N_CH*DATA_W-1:0]   o_ch_value,
  output logic                     o_ovf,
  output logic [15:0]              o_ipc_q88,
  output logic                     o_done
);

  localparam int QW = CNT_W + 8;
  localparam int SW = $clog2(QW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [N_CH*DATA_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]         cycle_q, cycle_d;
  logic [CNT_W-1:0]         insn_q, insn_d;
  logic [CNT_W-1:0]         bubble_q, bubble_d;
  logic                     ovf_q, ovf_d;
  logic [N_CH-1:0]          changed_q, changed_d;
  logic [N_CH*CNT_W-1:0]    ch_time_q, ch_time_d;
  logic [N_CH*DATA_W-1:0]   ch_value_q, ch_value_d;
  logic [CNT_W-1:0]         rem_q, rem_d;
  logic [QW-1:0]            div_q, div_d;
  logic [SW-1:0]            step_q, step_d;
  logic [15:0]              ipc_q, ipc_d;

  logic                     active;
  logic                     pc_zero;
  logic                     cyc_sat, insn_sat, bub_sat;
  logic [CNT_W-1:0]         cyc_inc;
  logic                     stop_hit;
  logic [CNT_W:0]           rem_shift, rem_nx;
  logic                     div_ge;
  logic [QW-1:0]            div_nx;
  logic                     unused_rem_msb;

  assign pc_zero = (i_pc_debug == '0);
  assign active  = (state_q == S_RUN) || ((state_q == S_IDLE) && !pc_zero);
  assign cyc_sat  = (cycle_q == CNT_MAX);
  assign insn_sat = (insn_q == CNT_MAX);
  assign bub_sat  = (bubble_q == CNT_MAX);
  assign cyc_inc  = cyc_sat ? cycle_q : cycle_q + 1'b1;

  // One restoring-division step: quotient bits shift into the dividend register.
  assign rem_shift = {rem_q, div_q[QW-1]};
  assign div_ge    = (rem_shift >= {1'b0, cycle_q});
  assign rem_nx    = div_ge ? (rem_shift - {1'b0, cycle_q}) : rem_shift;
  assign div_nx    = {div_q[QW-2:0], div_ge};
  assign unused_rem_msb = rem_nx[CNT_W];

  always_comb begin
    state_d    = state_q;
    shadow_d   = i_ch_data;
    cycle_d    = cycle_q;
    insn_d     = insn_q;
    bubble_d   = bubble_q;
    ovf_d      = ovf_q;
    changed_d  = changed_q;
    ch_time_d  = ch_time_q;
    ch_value_d = ch_value_q;
    rem_d      = rem_q;
    div_d      = div_q;
    step_d     = step_q;
    ipc_d      = ipc_q;
    stop_hit   = 1'b0;

    if (active) begin
      cycle_d = cyc_inc;
      if (i_insn_vld && !insn_sat) insn_d = insn_q + 1'b1;
      if (pc_zero && !bub_sat) bubble_d = bubble_q + 1'b1;
      if (cyc_sat || (i_insn_vld && insn_sat) || (pc_zero && bub_sat)) ovf_d = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (!changed_q[k] &&
            (i_ch_data[k*DATA_W +: DATA_W] != shadow_q[k*DATA_W +: DATA_W])) begin
          changed_d[k]                   = 1'b1;
          ch_time_d[k*CNT_W +: CNT_W]    = cyc_inc;
          ch_value_d[k*DATA_W +: DATA_W] = i_ch_data[k*DATA_W +: DATA_W];
        end
      end
      stop_hit = i_stop ||
                 ((i_stop_mask != '0) && ((i_stop_mask & ~changed_d) == '0));
    end

    case (state_q)
      S_IDLE: begin
        if (!pc_zero) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop_hit) begin
          state_d = S_CALC;
          rem_d   = '0;
          div_d   = {insn_d, 8'h00};
          step_d  = '0;
        end
      end
      S_CALC: begin
        rem_d  = rem_nx[CNT_W-1:0];
        div_d  = div_nx;
        step_d = step_q + 1'b1;
        if (step_q == SW'(QW - 1)) begin
          state_d = S_DONE;
          if (cycle_q == '0)
            ipc_d = 16'h0000;
          else if (|(div_nx >> 16))
            ipc_d = 16'hFFFF;
          else
            ipc_d = div_nx[15:0];
        end
      end
      default: ;
    endcase

    if (i_clr) begin
      state_d    = S_IDLE;
      shadow_d   = '0;
      cycle_d    = '0;
      insn_d     = '0;
      bubble_d   = '0;
      ovf_d      = 1'b0;
      changed_d  = '0;
      ch_time_d  = '0;
      ch_value_d = '0;
      rem_d      = '0;
      div_d      = '0;
      step_d     = '0;
      ipc_d      = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      cycle_q    <= '0;
      insn_q     <= '0;
      bubble_q   <= '0;
      ovf_q      <= 1'b0;
      changed_q  <= '0;
      ch_time_q  <= '0;
      ch_value_q <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      step_q     <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cycle_q    <= cycle_d;
      insn_q     <= insn_d;
      bubble_q   <= bubble_d;
      ovf_q      <= ovf_d;
      changed_q  <= changed_d;
      ch_time_q  <= ch_time_d;
      ch_value_q <= ch_value_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      step_q     <= step_d;
      ipc_q      <= ipc_d;
    end
  end

  assign o_state      = state_q;
  assign o_cycle_cnt  = cycle_q;
  assign o_insn_cnt   = insn_q;
  assign o_bubble_cnt = bubble_q;
  assign o_ch_changed = changed_q;
  assign o_ch_time    = ch_time_q;
  assign o_ch_value   = ch_value_q;
  assign o_ovf        = ovf_q;
  assign o_ipc_q88    = ipc_q;
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor - directed checks of perf_monitor with 16-bit and 8-bit counter instances
module tb_perf_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mask = 2'b00;
  logic [31:0] pc = '0;
  logic        vld = 1'b0;
  logic [63:0] chd = '0;

  logic [1:0]  a_state, b_state;
  logic [15:0] a_cycle, a_insn, a_bubble;
  logic [7:0]  b_cycle, b_insn, b_bubble;
  logic [1:0]  a_changed, b_changed;
  logic [31:0] a_time;
  logic [15:0] b_time;
  logic [63:0] a_val, b_val;
  logic        a_ovf, b_ovf, a_done, b_done;
  logic [15:0] a_ipc, b_ipc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(16), .PC_W(32), .DATA_W(32), .N_CH(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_stop(stop), .i_stop_mask(mask),
    .i_pc_debug(pc), .i_insn_vld(vld), .i_ch_data(chd),
    .o_state(a_state), .o_cycle_cnt(a_cycle), .o_insn_cnt(a_insn), .o_bubble_cnt(a_bubble),
    .o_ch_changed(a_changed), .o_ch_time(a_time), .o_ch_value(a_val),
    .o_ovf(a_ovf), .o_ipc_q88(a_ipc), .o_done(a_done)
  );

  perf_monitor #(.CNT_W(8), .PC_W(32), .DATA_W(32), .N_CH(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_stop(stop), .i_stop_mask(mask),
    .i_pc_debug(pc), .i_insn_vld(vld), .i_ch_data(chd),
    .o_state(b_state), .o_cycle_cnt(b_cycle), .o_insn_cnt(b_insn), .o_bubble_cnt(b_bubble),
    .o_ch_changed(b_changed), .o_ch_time(b_time), .o_ch_value(b_val),
    .o_ovf(b_ovf), .o_ipc_q88(b_ipc), .o_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    pc = '0; vld = 1'b0; stop = 1'b0; chd = '0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_cycle", 32'(a_cycle), 32'd0);
    check("rst_ipc", 32'(a_ipc), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    rst_n = 1'b1;

    // Test 1: three bubbles in IDLE, ten retiring cycles, ch0 stops the run
    mask = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    check("t1_idle_state", 32'(a_state), 32'd0);
    check("t1_idle_cycle", 32'(a_cycle), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      pc = 32'h100 + 32'(i); vld = 1'b1;
      if (i == 10) chd[31:0] = 32'd120;
      tick();
      if (i == 9) check("t1_run_state", 32'(a_state), 32'd1);
    end
    pc = '0; vld = 1'b0;
    check("t1_state_calc", 32'(a_state), 32'd2);
    check("t1_cycle", 32'(a_cycle), 32'd10);
    check("t1_insn", 32'(a_insn), 32'd10);
    check("t1_bubble", 32'(a_bubble), 32'd0);
    check("t1_time0", 32'(a_time[15:0]), 32'd10);
    check("t1_value0", a_val[31:0], 32'd120);
    check("t1_changed", 32'(a_changed), 32'b01);
    for (int i = 0; i < 23; i++) tick();
    check("t1_calc_23", 32'(a_state), 32'd2);
    tick();
    check("t1_done_state", 32'(a_state), 32'd3);
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_ipc", 32'(a_ipc), 32'h0100);
    do_clear();
    check("clr_state", 32'(a_state), 32'd0);
    check("clr_cycle", 32'(a_cycle), 32'd0);
    check("clr_changed", 32'(a_changed), 32'd0);
    check("clr_ipc", 32'(a_ipc), 32'd0);

    // Test 2: 20 RUN cycles, five bubble slots, manual stop
    for (int i = 1; i <= 20; i++) begin
      pc = (i % 3 == 0 && i <= 15) ? 32'h0 : 32'h200;
      vld = (pc != 0);
      stop = (i == 20);
      tick();
    end
    pc = '0; vld = 1'b0; stop = 1'b0;
    check("t2_cycle", 32'(a_cycle), 32'd20);
    check("t2_insn", 32'(a_insn), 32'd15);
    check("t2_bubble", 32'(a_bubble), 32'd5);
    for (int i = 0; i < 24; i++) tick();
    check("t2_done", 32'(a_done), 32'd1);
    check("t2_ipc", 32'(a_ipc), 32'h00C0);
    do_clear();

    // Test 3: both channels masked, ch1 changes twice before ch0 changes
    mask = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      pc = 32'h300; vld = 1'b1;
      if (i == 4) chd[63:32] = 32'd5;
      if (i == 6) chd[63:32] = 32'd7;
      if (i == 12) chd[31:0] = 32'd9;
      tick();
      if (i == 11) check("t3_run_11", 32'(a_state), 32'd1);
    end
    pc = '0; vld = 1'b0;
    check("t3_state_calc", 32'(a_state), 32'd2);
    check("t3_cycle", 32'(a_cycle), 32'd12);
    check("t3_changed", 32'(a_changed), 32'b11);
    check("t3_time1", 32'(a_time[31:16]), 32'd4);
    check("t3_value1", a_val[63:32], 32'd5);
    check("t3_time0", 32'(a_time[15:0]), 32'd12);
    check("t3_value0", a_val[31:0], 32'd9);
    do_clear();

    // Test 4: empty mask, only the manual stop ends the run; then clear beats stop
    mask = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      pc = 32'h400; vld = 1'b1;
      if (i == 2) chd[31:0] = 32'd3;
      stop = (i == 7);
      tick();
      if (i == 6) check("t4_run_6", 32'(a_state), 32'd1);
    end
    stop = 1'b0;
    check("t4_state_calc", 32'(a_state), 32'd2);
    check("t4_cycle", 32'(a_cycle), 32'd7);
    check("t4_changed", 32'(a_changed), 32'b01);
    do_clear();
    for (int i = 0; i < 3; i++) begin
      pc = 32'h400; vld = 1'b1;
      tick();
    end
    clr = 1'b1; stop = 1'b1;
    tick();
    clr = 1'b0; stop = 1'b0; pc = '0; vld = 1'b0;
    check("t4_clr_state", 32'(a_state), 32'd0);
    check("t4_clr_cycle", 32'(a_cycle), 32'd0);
    check("t4_clr_insn", 32'(a_insn), 32'd0);

    // Test 5: 300 cycles saturates the 8-bit instance
    for (int i = 1; i <= 300; i++) begin
      pc = 32'h500; vld = 1'b1;
      stop = (i == 300);
      tick();
    end
    stop = 1'b0; pc = '0; vld = 1'b0;
    check("t5_b_state", 32'(b_state), 32'd2);
    check("t5_b_cycle", 32'(b_cycle), 32'd255);
    check("t5_b_insn", 32'(b_insn), 32'd255);
    check("t5_b_ovf", 32'(b_ovf), 32'd1);
    check("t5_a_cycle", 32'(a_cycle), 32'd300);
    check("t5_a_ovf", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("t5_b_calc_15", 32'(b_state), 32'd2);
    tick();
    check("t5_b_done", 32'(b_state), 32'd3);
    check("t5_b_ipc", 32'(b_ipc), 32'h0100);
    do_clear();

    // Test 6: asynchronous reset mid-CALC, then re-arm
    for (int i = 1; i <= 5; i++) begin
      pc = 32'h600; vld = 1'b1;
      stop = (i == 5);
      tick();
    end
    stop = 1'b0;
    tick();
    tick();
    tick();
    check("t6_in_calc", 32'(a_state), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(a_state), 32'd0);
    check("t6_rst_cycle", 32'(a_cycle), 32'd0);
    check("t6_rst_insn", 32'(a_insn), 32'd0);
    check("t6_rst_ipc", 32'(a_ipc), 32'd0);
    check("t6_rst_done", 32'(a_done), 32'd0);
    #1 rst_n = 1'b1;
    pc = 32'h600; vld = 1'b1;
    tick();
    check("t6_rearm_state", 32'(a_state), 32'd1);
    check("t6_rearm_cycle", 32'(a_cycle), 32'd1);
    check("t6_rearm_insn", 32'(a_insn), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
